databus_merge: RTL and testbench

- N-to-1 native-bus merger between the Versat vector/stage databus ports (valid/addr/wdata/wstrb/rdata/ready) and the single L1-cache port of the external-memory subsystem.
- Round-robin arbitration; request fields registered at grant; one outstanding transaction at a time; response routed back to the granting master only.
- Inverse of the address split used on the CPU side: many masters to one slave.

---
 rtl/databus_merge_pkg.sv | 41 ++++
 rtl/databus_merge_if.sv | 17 +
 rtl/databus_merge_rr_arbiter.sv | 31 +++
 rtl/databus_merge.sv | 101 ++++++++++
 tb/tb_databus_merge.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/databus_merge_pkg.sv
// Shared definitions for the Versat databus merger: bus field widths/offsets
// and the arbitration FSM state type.
package databus_merge_pkg;

  localparam int DEF_N_MASTERS = 2;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;

  typedef enum logic {ARB = 1'b0, BUSY = 1'b1} state_t;

  // Flattened native-bus request: {valid, addr, wdata, wstrb}, valid at MSB.
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Flattened native-bus response: {ready, rdata}.
  function automatic int resp_w(input int data_w);
    return 1 + data_w;
  endfunction

  function automatic int wstrb_off();
    return 0;
  endfunction

  function automatic int wdata_off(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int addr_off(input int data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int valid_off(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/databus_merge_if.sv
// Native valid/ready bus carrying N lanes packed side by side; lane i of
// each field sits at [i*W +: W].
interface databus_merge_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N-1:0]          valid;
  logic [N*ADDR_W-1:0]   addr;
  logic [N*DATA_W-1:0]   wdata;
  logic [N*DATA_W/8-1:0] wstrb;
  logic [N*DATA_W-1:0]   rdata;
  logic [N-1:0]          ready;

  modport master (output valid, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/databus_merge_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr_i, wrapping.
module databus_merge_rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    // k runs 1..N so ptr_i itself is scanned last
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/databus_merge.sv
// N-to-1 merger of Versat databus masters onto the single L1-cache port:
// round-robin grant, request registered at grant, one transaction in flight.
module databus_merge
  import databus_merge_pkg::*;
#(
  parameter int N_MASTERS = DEF_N_MASTERS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  databus_merge_if.slave               m,
  databus_merge_if.master              s,
  output logic                         busy,
  output logic [$clog2(N_MASTERS)-1:0] grant_id
);
  localparam int IDX_W  = $clog2(N_MASTERS);
  localparam int STRB_W = DATA_W / 8;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gid_q, gid_d;
  logic [N_MASTERS-1:0] goh_q, goh_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [STRB_W-1:0]    wstrb_q, wstrb_d;

  logic [N_MASTERS-1:0] arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  databus_merge_rr_arbiter #(.N(N_MASTERS)) u_arb (
    .req_i (m.valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
      ptr_q   <= IDX_W'(N_MASTERS - 1);
      gid_q   <= '0;
      goh_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      goh_q   <= goh_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    goh_d   = goh_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      ARB: begin
        if (arb_any) begin
          state_d = BUSY;
          gid_d   = arb_idx;
          goh_d   = arb_gnt;
          addr_d  = m.addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          wdata_d = m.wdata[int'(arb_idx)*DATA_W +: DATA_W];
          wstrb_d = m.wstrb[int'(arb_idx)*STRB_W +: STRB_W];
        end
      end
      BUSY: begin
        // Masters may drop valid here; the registered request still completes
        if (s.ready[0]) begin
          state_d = ARB;
          ptr_d   = gid_q;
        end
      end
      default: state_d = ARB;
    endcase
  end

  assign s.valid[0] = (state_q == BUSY);
  assign s.addr     = addr_q;
  assign s.wdata    = wdata_q;
  assign s.wstrb    = wstrb_q;
  assign busy       = (state_q == BUSY);
  assign grant_id   = gid_q;

  // Completion passes straight through to the granted lane only
  assign m.ready = (state_q == BUSY && s.ready[0]) ? goh_q : '0;
  assign m.rdata = {N_MASTERS{s.rdata}};

endmodule

// File: tb/tb_databus_merge.sv
// Directed bench for databus_merge (N_MASTERS=2): reset, read, round robin,
// write with dropped valid, idle ready, async reset mid-transaction.
module tb_databus_merge;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [0:0] grant_id;
  logic       auto_ack = 1'b0;
  logic [0:0] ack_man  = 1'b0;
  int errors = 0;
  int checks = 0;

  databus_merge_if #(.N(N), .ADDR_W(AW), .DATA_W(DW)) mbus ();
  databus_merge_if #(.N(1), .ADDR_W(AW), .DATA_W(DW)) sbus ();

  databus_merge #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .m        (mbus),
    .s        (sbus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // Cache model: either answers in the same cycle as s_valid or is driven by hand
  always_comb sbus.ready = auto_ack ? sbus.valid : ack_man;

  task automatic idle_inputs();
    mbus.valid = '0;
    mbus.addr  = '0;
    mbus.wdata = '0;
    mbus.wstrb = '0;
    sbus.rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (sbus.valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid got=%b want=0", sbus.valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (mbus.ready !== 2'b00) begin errors++; $display("FAIL reset_m_ready got=%b want=00", mbus.ready); end
      checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant_id got=%0d want=0", grant_id); end
    end
    rst = 1'b1;
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    mbus.valid = 2'b10;
    mbus.addr[AW +: AW] = 32'h100;
    @(negedge clk);
    checks++; if (sbus.valid !== 1'b0) begin errors++; $display("FAIL read_pre_grant s_valid got=%b want=0", sbus.valid); end
    @(negedge clk);
    checks++; if (sbus.valid !== 1'b1) begin errors++; $display("FAIL read_s_valid got=%b want=1", sbus.valid); end
    checks++; if (sbus.addr !== 32'h100) begin errors++; $display("FAIL read_s_addr got=%h want=00000100", sbus.addr); end
    checks++; if (sbus.wstrb !== 4'b0000) begin errors++; $display("FAIL read_s_wstrb got=%b want=0000", sbus.wstrb); end
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL read_grant_id got=%0d want=1", grant_id); end
    checks++; if (mbus.ready !== 2'b00) begin errors++; $display("FAIL read_wait_ready got=%b want=00", mbus.ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy_hold got=%b want=1", busy); end
    checks++; if (mbus.ready !== 2'b00) begin errors++; $display("FAIL read_wait_ready2 got=%b want=00", mbus.ready); end
    @(posedge clk); #1;
    ack_man    = 1'b1;
    sbus.rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (mbus.ready !== 2'b10) begin errors++; $display("FAIL read_m_ready got=%b want=10", mbus.ready); end
    checks++; if (mbus.rdata[DW +: DW] !== 32'hDEADBEEF) begin errors++; $display("FAIL read_m_rdata got=%h want=deadbeef", mbus.rdata[DW +: DW]); end
    @(posedge clk); #1;
    ack_man    = 1'b0;
    mbus.valid = 2'b00;
    @(negedge clk);
    checks++; if (sbus.valid !== 1'b0) begin errors++; $display("FAIL read_done_s_valid got=%b want=0", sbus.valid); end
    checks++; if (mbus.ready !== 2'b00) begin errors++; $display("FAIL read_done_m_ready got=%b want=00", mbus.ready); end
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL read_done_grant_id got=%0d want=1", grant_id); end
  endtask

  task automatic test_round_robin();
    logic [0:0] exp_id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] exp_rdy;
    @(posedge clk); #1;
    auto_ack   = 1'b1;
    mbus.valid = 2'b11;
    mbus.addr  = {32'h0000_0B00, 32'h0000_0A00};
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (exp_id[i] == 1'b0) ? 2'b01 : 2'b10;
      @(posedge clk); @(negedge clk);
      checks++; if (grant_id !== exp_id[i]) begin errors++; $display("FAIL rr_grant[%0d] got=%0d want=%0d", i, grant_id, exp_id[i]); end
      checks++; if (mbus.ready !== exp_rdy) begin errors++; $display("FAIL rr_m_ready[%0d] got=%b want=%b", i, mbus.ready, exp_rdy); end
      checks++; if (sbus.addr !== (exp_id[i] ? 32'h0B00 : 32'h0A00)) begin errors++; $display("FAIL rr_s_addr[%0d] got=%h", i, sbus.addr); end
      if (i == 3) mbus.valid = 2'b00;
      @(posedge clk); @(negedge clk);
      checks++; if (mbus.ready !== 2'b00) begin errors++; $display("FAIL rr_gap_ready[%0d] got=%b want=00", i, mbus.ready); end
    end
    auto_ack = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_end_busy got=%b want=0", busy); end
  endtask

  task automatic test_write_drop();
    @(posedge clk); #1;
    mbus.valid = 2'b01;
    mbus.addr[0 +: AW]    = 32'h40;
    mbus.wdata[0 +: DW]   = 32'h12345678;
    mbus.wstrb[0 +: DW/8] = 4'b0011;
    @(posedge clk); #1;
    mbus.valid = 2'b00;
    mbus.addr[0 +: AW]    = 32'hFFF;
    mbus.wdata[0 +: DW]   = 32'hA5A5A5A5;
    mbus.wstrb[0 +: DW/8] = 4'b1111;
    @(negedge clk);
    checks++; if (sbus.addr !== 32'h40) begin errors++; $display("FAIL wr_s_addr got=%h want=00000040", sbus.addr); end
    checks++; if (sbus.wdata !== 32'h12345678) begin errors++; $display("FAIL wr_s_wdata got=%h want=12345678", sbus.wdata); end
    checks++; if (sbus.wstrb !== 4'b0011) begin errors++; $display("FAIL wr_s_wstrb got=%b want=0011", sbus.wstrb); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy got=%b want=1", busy); end
    @(posedge clk); #1;
    ack_man = 1'b1;
    @(negedge clk);
    checks++; if (mbus.ready !== 2'b01) begin errors++; $display("FAIL wr_m_ready got=%b want=01", mbus.ready); end
    checks++; if (sbus.addr !== 32'h40) begin errors++; $display("FAIL wr_s_addr_hold got=%h want=00000040", sbus.addr); end
    @(posedge clk); #1;
    ack_man = 1'b0;
    @(negedge clk);
    checks++; if (sbus.valid !== 1'b0) begin errors++; $display("FAIL wr_done_s_valid got=%b want=0", sbus.valid); end
  endtask

  task automatic test_idle_ready();
    @(posedge clk); #1;
    ack_man = 1'b1;
    @(negedge clk);
    checks++; if (mbus.ready !== 2'b00) begin errors++; $display("FAIL idle_m_ready got=%b want=00", mbus.ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b want=0", busy); end
    @(posedge clk); #1;
    ack_man = 1'b0;
    @(negedge clk);
    checks++; if (sbus.valid !== 1'b0) begin errors++; $display("FAIL idle_after_s_valid got=%b want=0", sbus.valid); end
    checks++; if (mbus.ready !== 2'b00) begin errors++; $display("FAIL idle_after_m_ready got=%b want=00", mbus.ready); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    mbus.valid = 2'b10;
    mbus.addr  = {32'h0000_0300, 32'h0000_0200};
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got=%b want=1", busy); end
    checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL rmid_grant_before got=%0d want=1", grant_id); end
    #3 rst = 1'b0;
    #1;
    checks++; if (sbus.valid !== 1'b0) begin errors++; $display("FAIL rmid_s_valid got=%b want=0", sbus.valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b want=0", busy); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rmid_grant_id got=%0d want=0", grant_id); end
    checks++; if (sbus.addr !== 32'h0) begin errors++; $display("FAIL rmid_s_addr got=%h want=0", sbus.addr); end
    mbus.valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    mbus.valid = 2'b11;
    @(posedge clk); #1;
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL rmid_prio_grant got=%0d want=0", grant_id); end
    checks++; if (sbus.addr !== 32'h200) begin errors++; $display("FAIL rmid_prio_addr got=%h want=00000200", sbus.addr); end
    ack_man = 1'b1;
    @(negedge clk);
    checks++; if (mbus.ready !== 2'b01) begin errors++; $display("FAIL rmid_prio_ready got=%b want=01", mbus.ready); end
    mbus.valid = 2'b00;
    @(posedge clk); #1;
    ack_man = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_write_drop();
    test_idle_ready();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
